// File: rtl/mux_rr_stream_if.sv
// mux_rr_stream_if: bundle of the N input streams and the single output stream
// of the round-robin stream multiplexer.
//   in_data   N_INPUTS*WIDTH  channel i beat in bits [i*WIDTH +: WIDTH]
//   in_valid  N_INPUTS        channel i offers a beat
//   in_last   N_INPUTS        channel i's beat ends its packet
//   in_ready  N_INPUTS        channel i's beat is accepted this cycle
//   out_data  WIDTH           registered output beat
//   out_valid 1               output register holds a beat
//   out_last  1               output beat ends its packet
//   out_sel   SEL_W           source channel of the output beat
//   out_ready 1               consumer accepts the output beat
// Modport master is the producer/consumer side, slave is the multiplexer.
interface mux_rr_stream_if #(
  parameter int WIDTH    = 8,
  parameter int N_INPUTS = 4
);
  localparam int SEL_W = $clog2(N_INPUTS);

  logic [N_INPUTS*WIDTH-1:0] in_data;
  logic [N_INPUTS-1:0]       in_valid;
  logic [N_INPUTS-1:0]       in_last;
  logic [N_INPUTS-1:0]       in_ready;
  logic [WIDTH-1:0]          out_data;
  logic                      out_valid;
  logic                      out_last;
  logic [SEL_W-1:0]          out_sel;
  logic                      out_ready;

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_valid, out_last, out_sel
  );

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_data, out_valid, out_last, out_sel
  );
endinterface

// File: rtl/mux_rr_stream.sv
// mux_rr_stream: N-input round-robin stream multiplexer with packet locking and
// a single registered output stage (1 beat/cycle, 1 clk accept-to-output).
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  mux_rr_stream_if.slave: input streams in, merged output stream out
module mux_rr_stream #(
  parameter int WIDTH    = 8,
  parameter int N_INPUTS = 4
) (
  input logic            clk,
  input logic            rst,
  mux_rr_stream_if.slave bus
);
  localparam int SEL_W = $clog2(N_INPUTS);
  localparam int IW    = SEL_W + 1;

  logic [WIDTH-1:0] chan_data [N_INPUTS];

  // Arbitration state
  logic [SEL_W-1:0] rr_ptr;
  logic             locked;
  logic [SEL_W-1:0] lock_ch;

  // Output stage registers
  logic [WIDTH-1:0] data_p1;
  logic             last_p1;
  logic [SEL_W-1:0] sel_p1;
  logic             vld_p1;

  logic             load_en;
  logic             grant_exists;
  logic [SEL_W-1:0] grant;
  logic             accept;
  logic [IW-1:0]    scan_idx;

  function automatic logic [SEL_W-1:0] next_ptr(input logic [SEL_W-1:0] ch);
    if (ch == SEL_W'(N_INPUTS - 1)) return '0;
    return ch + SEL_W'(1);
  endfunction

  for (genvar i = 0; i < N_INPUTS; i++) begin : g_unpack
    assign chan_data[i] = bus.in_data[i*WIDTH +: WIDTH];
  end

  assign load_en = !vld_p1 || bus.out_ready;

  // Locked: only the packet owner may proceed, even if it has a gap.
  // Unlocked: first requester at or after rr_ptr, wrapping around.
  always_comb begin
    grant_exists = 1'b0;
    grant        = '0;
    scan_idx     = '0;
    if (locked) begin
      grant        = lock_ch;
      grant_exists = bus.in_valid[lock_ch];
    end else begin
      for (int k = 0; k < N_INPUTS; k++) begin
        scan_idx = {1'b0, rr_ptr} + IW'(k);
        if (scan_idx >= IW'(N_INPUTS)) scan_idx = scan_idx - IW'(N_INPUTS);
        if (!grant_exists && bus.in_valid[scan_idx[SEL_W-1:0]]) begin
          grant_exists = 1'b1;
          grant        = scan_idx[SEL_W-1:0];
        end
      end
    end
  end

  assign accept      = load_en && grant_exists;
  assign bus.in_ready = accept ? (N_INPUTS'(1) << grant) : '0;

  // Stage p1: output register and arbitration state update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      last_p1 <= 1'b0;
      sel_p1  <= '0;
      rr_ptr  <= '0;
      locked  <= 1'b0;
      lock_ch <= '0;
    end else if (load_en) begin
      if (accept) begin
        vld_p1  <= 1'b1;
        data_p1 <= chan_data[grant];
        last_p1 <= bus.in_last[grant];
        sel_p1  <= grant;
        if (bus.in_last[grant]) begin
          locked <= 1'b0;
          rr_ptr <= next_ptr(grant);
        end else begin
          locked  <= 1'b1;
          lock_ch <= grant;
        end
      end else begin
        vld_p1 <= 1'b0;
      end
    end
  end

  assign bus.out_data  = data_p1;
  assign bus.out_last  = last_p1;
  assign bus.out_sel   = sel_p1;
  assign bus.out_valid = vld_p1;
endmodule

// File: tb/tb_mux_rr_stream.sv
// tb_mux_rr_stream: directed scenarios plus a randomized run against a
// packet-level reference model and a per-channel scoreboard.
module tb_mux_rr_stream;
  localparam int W = 8;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] iv  = '0;
  logic [N*W-1:0] id = '0;
  logic [N-1:0] il  = '0;
  logic         ordy = 1'b1;

  int n_checks = 0;
  int n_errors = 0;

  mux_rr_stream_if #(.WIDTH(W), .N_INPUTS(N)) bus ();

  assign bus.in_valid  = iv;
  assign bus.in_data   = id;
  assign bus.in_last   = il;
  assign bus.out_ready = ordy;

  mux_rr_stream #(.WIDTH(W), .N_INPUTS(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int c, input logic v, input logic [7:0] d, input logic l);
    iv[c]         = v;
    id[c*W +: W]  = d;
    il[c]         = l;
  endtask

  task automatic do_reset();
    iv   = '0;
    il   = '0;
    ordy = 1'b1;
    rst  = 1'b1;
    tick();
    rst  = 1'b0;
  endtask

  task automatic check_out(input string tag, input logic [7:0] d, input int sel, input logic l);
    check_val({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    check_val({tag, "_data"},  32'(bus.out_data),  32'(d));
    check_val({tag, "_sel"},   32'(bus.out_sel),   32'(sel));
    check_val({tag, "_last"},  32'(bus.out_last),  32'(l));
  endtask

  // Reference model state (packet-level rules, plain arithmetic)
  logic [8:0] pend [N][$];
  logic [8:0] sb   [N][$];
  logic       m_vld, m_last, m_locked;
  logic [7:0] m_data;
  int         m_sel, m_ptr, m_lock;

  initial begin
    int seq2 [6];
    int seq6 [4];
    logic [8:0] w;
    int len, g, c, s, pkt_ch;
    logic load, gex, in_pkt;
    logic [N-1:0] exp_rdy;

    // 1. Reset values and reset mid-packet
    #1;
    check_val("rst_out_valid", 32'(bus.out_valid), 32'd0);
    do_reset();
    check_val("rst_out_data", 32'(bus.out_data), 32'd0);
    check_val("rst_out_last", 32'(bus.out_last), 32'd0);
    check_val("rst_out_sel",  32'(bus.out_sel),  32'd0);
    drive(2, 1'b1, 8'h21, 1'b0);
    tick();
    check_out("t1_beat1", 8'h21, 2, 1'b0);
    drive(2, 1'b1, 8'h22, 1'b0);
    tick();
    rst = 1'b1;
    #1;
    check_val("t1_async_valid", 32'(bus.out_valid), 32'd0);
    check_val("t1_async_data",  32'(bus.out_data),  32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(0, 1'b1, 8'h01, 1'b1);
    drive(2, 1'b1, 8'h23, 1'b1);
    @(negedge clk);
    check_val("t1_ready_after_rst", 32'(bus.in_ready), 32'b0001);
    tick();
    check_out("t1_ch0_wins", 8'h01, 0, 1'b1);

    // 2. Fairness with all channels requesting single-beat packets
    do_reset();
    seq2 = '{0, 1, 2, 3, 0, 1};
    for (int i = 0; i < N; i++) drive(i, 1'b1, 8'(8'h10 + i), 1'b1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check_val("t2_ready", 32'(bus.in_ready), 32'(1 << seq2[k]));
      tick();
      check_out("t2_out", 8'(8'h10 + seq2[k]), seq2[k], 1'b1);
    end

    // 3. Lock holds a 3-beat packet against a competing requester
    do_reset();
    drive(2, 1'b1, 8'hB2, 1'b1);
    for (int k = 0; k < 3; k++) begin
      drive(1, 1'b1, 8'(8'hA1 + k), k == 2);
      tick();
      check_out("t3_pkt", 8'(8'hA1 + k), 1, k == 2);
    end
    drive(1, 1'b0, 8'h00, 1'b0);
    tick();
    check_out("t3_then_ch2", 8'hB2, 2, 1'b1);

    // 4. Lock survives a gap in the owner's valid
    do_reset();
    drive(1, 1'b1, 8'hC1, 1'b0);
    tick();
    check_out("t4_c1", 8'hC1, 1, 1'b0);
    drive(1, 1'b0, 8'h00, 1'b0);
    drive(0, 1'b1, 8'h0C, 1'b1);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check_val("t4_gap_ready", 32'(bus.in_ready), 32'd0);
      tick();
      check_val("t4_gap_bubble", 32'(bus.out_valid), 32'd0);
    end
    drive(1, 1'b1, 8'hC2, 1'b0);
    @(negedge clk);
    check_val("t4_resume_ready", 32'(bus.in_ready), 32'b0010);
    tick();
    check_out("t4_c2", 8'hC2, 1, 1'b0);
    drive(1, 1'b1, 8'hC3, 1'b1);
    tick();
    check_out("t4_c3", 8'hC3, 1, 1'b1);
    drive(1, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    check_val("t4_ch0_ready", 32'(bus.in_ready), 32'b0001);
    tick();
    check_out("t4_ch0", 8'h0C, 0, 1'b1);

    // 5. Backpressure
    do_reset();
    drive(3, 1'b1, 8'hD0, 1'b1);
    tick();
    check_out("t5_d0", 8'hD0, 3, 1'b1);
    ordy = 1'b0;
    drive(3, 1'b1, 8'hD1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_val("t5_stall_ready", 32'(bus.in_ready), 32'd0);
      check_out("t5_stall_hold", 8'hD0, 3, 1'b1);
      tick();
    end
    ordy = 1'b1;
    @(negedge clk);
    check_val("t5_release_ready", 32'(bus.in_ready), 32'b1000);
    tick();
    check_out("t5_d1", 8'hD1, 3, 1'b1);
    drive(3, 1'b1, 8'hD2, 1'b1);
    tick();
    check_out("t5_d2", 8'hD2, 3, 1'b1);
    drive(3, 1'b0, 8'h00, 1'b0);
    tick();
    check_val("t5_drained", 32'(bus.out_valid), 32'd0);

    // 6. Pointer wrap from 3 to 0
    do_reset();
    drive(2, 1'b1, 8'h2F, 1'b1);
    tick();
    check_out("t6_ptr_to_3", 8'h2F, 2, 1'b1);
    drive(2, 1'b0, 8'h00, 1'b0);
    drive(3, 1'b1, 8'h3A, 1'b1);
    drive(0, 1'b1, 8'h0A, 1'b1);
    seq6 = '{3, 0, 3, 0};
    for (int k = 0; k < 4; k++) begin
      tick();
      check_val("t6_wrap_sel", 32'(bus.out_sel), 32'(seq6[k]));
    end

    // Randomized run: reference model + per-channel scoreboard
    do_reset();
    m_vld = 1'b0; m_last = 1'b0; m_data = '0; m_sel = 0;
    m_ptr = 0; m_locked = 1'b0; m_lock = 0;
    in_pkt = 1'b0; pkt_ch = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (cyc < 2700 && pend[i].size() == 0 && $urandom_range(0, 3) == 0) begin
          len = $urandom_range(1, 4);
          for (int b = 0; b < len; b++) begin
            w = {b == len - 1, 8'($urandom)};
            pend[i].push_back(w);
            sb[i].push_back(w);
          end
        end
        if (pend[i].size() != 0 && $urandom_range(0, 9) < 7)
          drive(i, 1'b1, pend[i][0][7:0], pend[i][0][8]);
        else
          drive(i, 1'b0, 8'($urandom), 1'($urandom));
      end
      ordy = ($urandom_range(0, 3) != 0);
      @(negedge clk);

      load = !m_vld || ordy;
      gex  = 1'b0;
      g    = 0;
      if (m_locked) begin
        g   = m_lock;
        gex = iv[g];
      end else begin
        for (int k = 0; k < N; k++) begin
          c = (m_ptr + k) % N;
          if (!gex && iv[c]) begin
            gex = 1'b1;
            g   = c;
          end
        end
      end
      exp_rdy = (load && gex) ? N'(1 << g) : '0;
      check_val("rnd_in_ready", 32'(bus.in_ready), 32'(exp_rdy));
      check_val("rnd_out_valid", 32'(bus.out_valid), 32'(m_vld));
      if (m_vld) begin
        check_val("rnd_out_data", 32'(bus.out_data), 32'(m_data));
        check_val("rnd_out_sel",  32'(bus.out_sel),  32'(m_sel));
        check_val("rnd_out_last", 32'(bus.out_last), 32'(m_last));
      end

      if (bus.out_valid && ordy) begin
        s = int'(bus.out_sel);
        if (sb[s].size() == 0) begin
          check_val("sb_underflow", 32'd1, 32'd0);
        end else begin
          w = sb[s].pop_front();
          check_val("sb_beat", 32'({bus.out_last, bus.out_data}), 32'(w));
        end
        if (in_pkt) check_val("sb_no_interleave", 32'(s), 32'(pkt_ch));
        in_pkt = !bus.out_last;
        pkt_ch = s;
      end

      if (load) begin
        if (gex) begin
          w      = pend[g].pop_front();
          m_vld  = 1'b1;
          m_data = w[7:0];
          m_last = w[8];
          m_sel  = g;
          if (w[8]) begin
            m_locked = 1'b0;
            m_ptr    = (g + 1) % N;
          end else begin
            m_locked = 1'b1;
            m_lock   = g;
          end
        end else begin
          m_vld = 1'b0;
        end
      end
      tick();
    end
    for (int i = 0; i < N; i++)
      check_val("sb_drained", 32'(sb[i].size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
